// File: rtl/apu_result_if.sv
// APU result queue bus: datapath push side plus the core-facing rvalid/rready
// result handshake and queue status. The master drives pushes and rready; the
// slave (the queue) drives status and the head result.
interface apu_result_if #(
    parameter int DATA_W = 32,
    parameter int VREG_W = 128,
    parameter int VL_W   = 5,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4
);
    logic                         push_i;
    logic [1:0]                   src_i;
    logic                         sext_i;
    logic [VL_W-1:0]              vl_i;
    logic [1:0]                   vsew_i;
    logic [VREG_W-1:0]            vs2_data_i;
    logic [DATA_W-1:0]            scalar_i;
    logic [FLAG_W-1:0]            flags_i;
    logic                         full_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         overflow_o;
    logic                         apu_rvalid_o;
    logic                         apu_rready_i;
    logic [DATA_W-1:0]            apu_result_o;
    logic [FLAG_W-1:0]            apu_flags_o;

    modport master (
        output push_i, src_i, sext_i, vl_i, vsew_i, vs2_data_i, scalar_i, flags_i,
        output apu_rready_i,
        input  full_o, count_o, overflow_o, apu_rvalid_o, apu_result_o, apu_flags_o
    );

    modport slave (
        input  push_i, src_i, sext_i, vl_i, vsew_i, vs2_data_i, scalar_i, flags_i,
        input  apu_rready_i,
        output full_o, count_o, overflow_o, apu_rvalid_o, apu_result_o, apu_flags_o
    );
endinterface

// File: rtl/apu_result_queue.sv
// APU result queue: formats the scalar result (VL, VS2 element 0 with SEW
// extract/extend, scalar pass-through, zero) and buffers it in an in-order
// FIFO with a registered rvalid/result/flags handshake towards the core.
// Optional feature macro: APU_RESULT_BYPASS_EN -- when defined, a push into an
// empty queue is presented on the result port in the same cycle.
module apu_result_queue #(
    parameter int DATA_W = 32,
    parameter int VREG_W = 128,
    parameter int VL_W   = 5,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4
) (
    input logic        clk,
    input logic        reset,
    apu_result_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [FLAG_W-1:0] mem_flags  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    logic [DATA_W-1:0] fmt_result;
    logic [FLAG_W-1:0] fmt_flags;
    logic              empty;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              overflow_set;

    // Select and format the incoming result; illegal SEW zeroes it and flags bit 0.
    always_comb begin
        fmt_result = '0;
        fmt_flags  = bus.flags_i;
        case (bus.src_i)
            2'd0: fmt_result = DATA_W'(bus.vl_i);
            2'd1: begin
                case (bus.vsew_i)
                    2'd0: begin
                        if (bus.sext_i) fmt_result = DATA_W'($signed(bus.vs2_data_i[7:0]));
                        else            fmt_result = DATA_W'(bus.vs2_data_i[7:0]);
                    end
                    2'd1: begin
                        if (bus.sext_i) fmt_result = DATA_W'($signed(bus.vs2_data_i[15:0]));
                        else            fmt_result = DATA_W'(bus.vs2_data_i[15:0]);
                    end
                    2'd2: begin
                        if (bus.sext_i) fmt_result = DATA_W'($signed(bus.vs2_data_i[31:0]));
                        else            fmt_result = DATA_W'(bus.vs2_data_i[31:0]);
                    end
                    default: begin
                        fmt_result   = '0;
                        fmt_flags[0] = 1'b1;
                    end
                endcase
            end
            2'd2: fmt_result = bus.scalar_i;
            default: fmt_result = '0;
        endcase
    end

    // Queue control: pop on handshake, accept a push unless full without a pop.
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
        pop   = !empty && bus.apu_rready_i;
`ifdef APU_RESULT_BYPASS_EN
        // A push consumed straight through the bypass never occupies an entry.
        wr_en = bus.push_i && (!full || pop) && !(empty && bus.apu_rready_i);
`else
        wr_en = bus.push_i && (!full || pop);
`endif
        overflow_set = bus.push_i && full && !pop;
    end

    // Pointers, occupancy and sticky overflow; reset flushes and ignores push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)          rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en)        wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_en && !pop)      count <= count + CNT_W'(1);
            else if (!wr_en && pop) count <= count - CNT_W'(1);
            if (overflow_set) overflow <= 1'b1;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_result[wr_ptr] <= fmt_result;
            mem_flags[wr_ptr]  <= fmt_flags;
        end
    end

    // Core-facing outputs from the registered head; zero while empty.
    always_comb begin
        bus.apu_rvalid_o = !empty;
        bus.apu_result_o = empty ? '0 : mem_result[rd_ptr];
        bus.apu_flags_o  = empty ? '0 : mem_flags[rd_ptr];
`ifdef APU_RESULT_BYPASS_EN
        if (empty && bus.push_i) begin
            bus.apu_rvalid_o = 1'b1;
            bus.apu_result_o = fmt_result;
            bus.apu_flags_o  = fmt_flags;
        end
`endif
        bus.full_o     = full;
        bus.count_o    = count;
        bus.overflow_o = overflow;
    end
endmodule

// File: tb/tb_apu_result_queue.sv
// Scoreboard bench for apu_result_queue: a queue-based reference model
// predicts accepted results at each clock edge; a negedge monitor compares the
// head, status outputs and occupancy against the model.
module tb_apu_result_queue;
    localparam int DATA_W = 32;
    localparam int VREG_W = 128;
    localparam int VL_W   = 5;
    localparam int FLAG_W = 5;
    localparam int DEPTH  = 4;
`ifdef APU_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    apu_result_if #(.DATA_W(DATA_W), .VREG_W(VREG_W), .VL_W(VL_W),
                    .FLAG_W(FLAG_W), .DEPTH(DEPTH)) bus ();

    apu_result_queue #(.DATA_W(DATA_W), .VREG_W(VREG_W), .VL_W(VL_W),
                       .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: expected queue contents (result in [36:5], flags in [4:0]).
    logic [36:0] exp_q[$];
    int          occ = 0;
    bit          m_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // Result formatting computed arithmetically from the element width.
    function automatic logic [36:0] model_fmt(input int src, input bit sext, input int vl,
                                              input int vsew, input logic [31:0] vs2_lo,
                                              input logic [31:0] scal, input logic [4:0] fl);
        logic [31:0] r;
        logic [4:0]  f;
        longint      w, m, e;
        f = fl;
        r = '0;
        case (src)
            0: r = 32'(vl);
            1: begin
                if (vsew == 3) begin
                    r    = '0;
                    f[0] = 1'b1;
                end else begin
                    w = longint'(8) << vsew;
                    m = longint'(1) << w;
                    e = longint'(vs2_lo) % m;
                    if (sext && e >= m / 2) e = e - m;
                    r = 32'(e);
                end
            end
            2: r = scal;
            default: r = '0;
        endcase
        return {r, f};
    endfunction

    function automatic logic [36:0] cur_fmt();
        return model_fmt(int'(bus.src_i), bus.sext_i, int'(bus.vl_i), int'(bus.vsew_i),
                         bus.vs2_data_i[31:0], bus.scalar_i, bus.flags_i);
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin
        bit pop, take, acc;
        if (reset) begin
            exp_q.delete();
            occ   = 0;
            m_ovf = 1'b0;
        end else begin
            pop  = (occ != 0) && bus.apu_rready_i;
            take = BYP && (occ == 0) && bus.push_i && bus.apu_rready_i;
            if (bus.push_i && occ == DEPTH && !pop) m_ovf = 1'b1;
            acc = bus.push_i && (occ < DEPTH || pop) && !take;
            if (acc) exp_q.push_back(cur_fmt());
            occ = occ - int'(pop) + int'(acc);
        end
    end

    // Monitor: compare status and head between edges; retire head on handshake.
    always @(negedge clk) begin
        logic [36:0] head;
        bit          hv;
        hv   = 1'b0;
        head = '0;
        if (occ != 0 && exp_q.size() != 0) begin
            hv   = 1'b1;
            head = exp_q[0];
        end else if (BYP && occ == 0 && bus.push_i) begin
            hv   = 1'b1;
            head = cur_fmt();
        end
        check("count", 64'(bus.count_o), 64'(occ));
        check("full", 64'(bus.full_o), 64'(occ == DEPTH));
        check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
        check("rvalid", 64'(bus.apu_rvalid_o), 64'(hv));
        check("result", 64'(bus.apu_result_o), 64'(head[36:5]));
        check("flags", 64'(bus.apu_flags_o), 64'(head[4:0]));
        if (occ != 0 && bus.apu_rready_i && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    task automatic step(input bit push, input int src, input bit sext, input int vsew,
                        input int vl, input logic [31:0] vs2_lo, input logic [31:0] scal,
                        input bit rr);
        bus.push_i       = push;
        bus.src_i        = 2'(src);
        bus.sext_i       = sext;
        bus.vsew_i       = 2'(vsew);
        bus.vl_i         = VL_W'(vl);
        bus.vs2_data_i   = {$urandom, $urandom, $urandom, vs2_lo};
        bus.scalar_i     = scal;
        bus.flags_i      = FLAG_W'($urandom);
        bus.apu_rready_i = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 32'h0, 32'h0, rr);
    endtask

    task automatic push_scalar(input logic [31:0] v, input bit rr);
        step(1'b1, 2, 1'b0, 0, 0, $urandom, v, rr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.push_i = 1'b0; bus.src_i = '0; bus.sext_i = 1'b0; bus.vl_i = '0;
        bus.vsew_i = '0; bus.vs2_data_i = '0; bus.scalar_i = '0; bus.flags_i = '0;
        bus.apu_rready_i = 1'b0;
        idle(1'b0, 2);
        reset = 1'b0;

        // VL result appears one cycle after the push, then drains.
        step(1'b1, 0, 1'b0, 0, 16, 32'h0, 32'h0, 1'b1);
        idle(1'b1, 2);

        // VS2 element formatting for each SEW.
        step(1'b1, 1, 1'b1, 0, 0, 32'h1234_80F0, 32'h0, 1'b1);
        step(1'b1, 1, 1'b0, 1, 0, 32'h1234_80F0, 32'h0, 1'b1);
        step(1'b1, 1, 1'b1, 2, 0, 32'h1234_80F0, 32'h0, 1'b1);
        step(1'b1, 1, 1'b0, 3, 0, 32'h1234_80F0, 32'h0, 1'b1);
        step(1'b1, 1, 1'b1, 1, 0, 32'h0000_7FFF, 32'h0, 1'b1);
        step(1'b1, 3, 1'b0, 0, 31, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1);
        idle(1'b1, 2);

        // Fill under back-pressure, overflow on the fifth push, then drain.
        for (int i = 1; i <= 5; i++) push_scalar(32'(i), 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 6);
        reset = 1'b1; idle(1'b0, 1); reset = 1'b0;

        // Full with simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 4; i++) push_scalar(32'(10 + i), 1'b0);
        for (int i = 0; i < 6; i++) push_scalar(32'(20 + i), 1'b1);
        idle(1'b1, 6);

        // Mid-operation reset with a push in the reset cycle.
        for (int i = 0; i < 3; i++) push_scalar(32'(40 + i), 1'b0);
        reset = 1'b1;
        push_scalar(32'h99, 1'b1);
        reset = 1'b0;
        push_scalar(32'h77, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Empty queue, push with rready high in the same cycle.
        push_scalar(32'hA5, 1'b1);
        idle(1'b1, 2);

        // Randomised traffic with back-pressure and occasional reset.
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom,
                 $urandom, $urandom_range(0, 9) < 5);
        end
        reset = 1'b0;

        // Bounded drain.
        for (int i = 0; i < 20 && occ != 0; i++) idle(1'b1, 1);
        check("drain", 64'(occ), 64'(0));
        idle(1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
